// File: rtl/raycast_pkg.sv
// Shared definitions for the raycaster column path.
//   COL_W            width of one column entry
//   DEFAULT_NUM_COLS columns per frame unless overridden at the top level
//   COMMIT_WORD      in-band write that publishes the back buffer
//   column_t         field layout of a column entry
//   loader_state_t   column_frame_loader state encoding
package raycast_pkg;

  localparam int          COL_W            = 28;
  localparam int          DEFAULT_NUM_COLS = 640;
  localparam logic [15:0] COMMIT_WORD      = 16'hFFFF;

  typedef struct packed {
    logic [2:0]  tex_type;
    logic [5:0]  tex_col;
    logic [2:0]  shade;
    logic [15:0] height;
  } column_t;

  typedef enum logic [1:0] {
    ACCEPT_LO   = 2'd0,
    ACCEPT_HI   = 2'd1,
    COMMIT_WAIT = 2'd2,
    CLEAR       = 2'd3
  } loader_state_t;

endpackage

// File: rtl/column_ram.sv
// Simple dual-port column RAM: one synchronous write port, one registered
// read port. Written in the block-RAM inference template.
//   clk          clock
//   we/waddr/wdata  write port
//   raddr        read address, sampled at clk
//   rdata        registered read data
module column_ram #(
  parameter int DEPTH = 1280,
  parameter int DW    = 28,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/column_frame_loader.sv
// Avalon-MM write-side loader for the ping-pong column RAM. Two 16-bit
// writes form one 28-bit column entry in the back buffer; the commit word
// 16'hFFFF makes the back buffer the front one at the next frame_start.
// Optional build macro: COLUMN_LOADER_CLEAR_EN (zero both buffers after reset).
//   clk, reset      clock, asynchronous active-high reset
//   chipselect, write, writedata, waitrequest   Avalon-MM slave write port
//   frame_start     one-cycle pulse at start of vertical blank
//   rd_col, rd_data front-buffer read port, 1-cycle latency
//   commit_pending  commit seen, swap not yet done
//   overflow        sticky: data arrived after the last column was complete
module column_frame_loader
  import raycast_pkg::*;
#(
  parameter int NUM_COLS = DEFAULT_NUM_COLS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        chipselect,
  input  logic                        write,
  input  logic [15:0]                 writedata,
  output logic                        waitrequest,
  input  logic                        frame_start,
  input  logic [$clog2(NUM_COLS)-1:0] rd_col,
  output logic [COL_W-1:0]            rd_data,
  output logic                        commit_pending,
  output logic                        overflow
);

  localparam int AW = $clog2(NUM_COLS);
  // Counter needs to hold NUM_COLS itself (saturation value).
  localparam int CW = $clog2(NUM_COLS + 1);
  localparam int RW = $clog2(2 * NUM_COLS);
  localparam logic [CW-1:0] FULL = CW'(NUM_COLS);
  localparam logic [RW-1:0] HALF = RW'(NUM_COLS);

  loader_state_t   state;
  logic [CW-1:0]   col_cnt;
  logic            front_sel;
  logic [11:0]     upper_q;
  logic            rd_zero;

  logic            accept;
  logic            is_commit;
  logic            full;
  logic            rd_in_range;
  logic            ram_we;
  logic [RW-1:0]   ram_waddr;
  logic [COL_W-1:0] ram_wdata;
  logic [RW-1:0]   ram_raddr;
  logic [COL_W-1:0] ram_rdata;

`ifdef COLUMN_LOADER_CLEAR_EN
  localparam logic [RW-1:0] CLR_LAST = RW'(2 * NUM_COLS - 1);
  logic [RW-1:0] clr_cnt;
`endif

  // Buffer b occupies linear addresses [b*NUM_COLS, b*NUM_COLS + NUM_COLS).
  function automatic logic [RW-1:0] buf_addr(input logic sel, input logic [AW-1:0] col);
    return sel ? (RW'(col) + HALF) : RW'(col);
  endfunction

  assign waitrequest    = (state == COMMIT_WAIT) || (state == CLEAR);
  assign commit_pending = (state == COMMIT_WAIT);
  assign accept         = chipselect && write && !waitrequest;
  assign is_commit      = (writedata == COMMIT_WORD);
  assign full           = (col_cnt == FULL);
  assign rd_in_range    = ({1'b0, rd_col} < (AW + 1)'(NUM_COLS));

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = buf_addr(~front_sel, col_cnt[AW-1:0]);
    ram_wdata = {upper_q, writedata};
`ifdef COLUMN_LOADER_CLEAR_EN
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_waddr = clr_cnt;
      ram_wdata = '0;
    end else
`endif
    if ((state == ACCEPT_HI) && accept && !is_commit && !full) begin
      ram_we = 1'b1;
    end
  end

  assign ram_raddr = buf_addr(front_sel, rd_in_range ? rd_col : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
`ifdef COLUMN_LOADER_CLEAR_EN
      state   <= CLEAR;
      clr_cnt <= '0;
`else
      state   <= ACCEPT_LO;
`endif
      col_cnt   <= '0;
      front_sel <= 1'b0;
      upper_q   <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        ACCEPT_LO: begin
          if (accept) begin
            if (is_commit) begin
              state <= COMMIT_WAIT;
            end else begin
              upper_q <= writedata[11:0];
              state   <= ACCEPT_HI;
              if (full) overflow <= 1'b1;
            end
          end
        end
        ACCEPT_HI: begin
          if (accept) begin
            if (is_commit) begin
              state <= COMMIT_WAIT;
            end else begin
              state <= ACCEPT_LO;
              if (full) overflow <= 1'b1;
              else      col_cnt  <= col_cnt + 1'b1;
            end
          end
        end
        COMMIT_WAIT: begin
          if (frame_start) begin
            front_sel <= ~front_sel;
            col_cnt   <= '0;
            overflow  <= 1'b0;
            state     <= ACCEPT_LO;
          end
        end
`ifdef COLUMN_LOADER_CLEAR_EN
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == CLR_LAST) state <= ACCEPT_LO;
        end
`endif
        default: state <= ACCEPT_LO;
      endcase
    end
  end

  // Out-of-range and clear-time reads return zero; the flag is registered
  // alongside the RAM read so it lines up with ram_rdata.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_zero <= 1'b1;
    else       rd_zero <= !rd_in_range || (state == CLEAR);
  end

  assign rd_data = rd_zero ? '0 : ram_rdata;

  column_ram #(
    .DEPTH(2 * NUM_COLS),
    .DW   (COL_W),
    .AW   (RW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

endmodule
